// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional baud-rate generator.
package baud_pkg;

    localparam int unsigned DIV_W_DEF  = 16;
    localparam int unsigned FRAC_W_DEF = 8;

    // Shortest usable os period in clock cycles; smaller divisors are clamped to it.
    localparam int unsigned MIN_DIV = 2;

    typedef enum logic [1:0] {
        CfgIdle,
        CfgPend,
        CfgDone
    } cfg_state_e;

    // Integer part of clock_freq / (baud_rate * oversample), rounded down.
    function automatic longint unsigned d0_int(input longint unsigned clock_freq,
                                               input longint unsigned baud_rate,
                                               input longint unsigned oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

    // Fractional part of the same ratio in units of 2^-frac_w, rounded down.
    function automatic longint unsigned d0_frac(input longint unsigned clock_freq,
                                                input longint unsigned baud_rate,
                                                input longint unsigned oversample,
                                                input int unsigned     frac_w);
        longint unsigned den;
        longint unsigned rem;
        den = baud_rate * oversample;
        rem = clock_freq % den;
        return (rem << frac_w) / den;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: counts clk cycles per oversample period and flags the
// last cycle of each period. Period length is div_int (clamped to MIN_DIV) plus the
// carry out of a phase accumulator fed with div_frac.
// Build option: BAUD_GEN_FRAC_EN enables the accumulator; without it the period is
// always div_int and div_frac is ignored.
module baud_frac_div
    import baud_pkg::*;
#(
    parameter int unsigned DIV_W  = DIV_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              clear,
    input  logic              acc_clear,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              period_end
);

    localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(MIN_DIV);
    localparam logic [DIV_W:0]   ONE_EXT = (DIV_W + 1)'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] int_eff;
    logic [DIV_W:0]   period;
    logic             carry;

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac};
    assign carry   = acc_sum[FRAC_W];

    // Accumulator advances once per completed period; cleared on resync or divisor load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
        end else if (clear || acc_clear) begin
            acc_q <= '0;
        end else if (period_end) begin
            acc_q <= acc_sum[FRAC_W-1:0];
        end
    end
`else
    logic unused_frac_path;
    assign unused_frac_path = ^{div_frac, acc_clear};
    assign carry            = 1'b0;
`endif

    assign int_eff = (div_int < MIN_INT) ? MIN_INT : div_int;
    assign period  = {1'b0, int_eff} + {{DIV_W{1'b0}}, carry};

    // >= rather than == so a divisor shrunk mid-period cannot overrun the counter.
    assign period_end = enable && !clear && ({1'b0, cnt_q} >= (period - ONE_EXT));

    // Cycle counter within the current oversample period; holds while disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= period_end ? '0 : cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick, per-bit tick and a square-wave
// baud clock. Divisor is reloadable through a valid/ready slot and takes effect on
// the next bit boundary; resync restarts the phase at mid-bit.
// Build option: BAUD_GEN_FRAC_EN enables the fractional accumulator.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 12000000,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = DIV_W_DEF,
    parameter int unsigned FRAC_W     = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              resync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div_int,
    input  logic [FRAC_W-1:0] cfg_div_frac,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              baud_clock
);

    localparam logic [DIV_W-1:0] D0_INT =
        DIV_W'(d0_int(64'(CLOCK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE)));
`ifdef BAUD_GEN_FRAC_EN
    localparam logic [FRAC_W-1:0] D0_FRAC =
        FRAC_W'(d0_frac(64'(CLOCK_FREQ), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_W));
`else
    localparam logic [FRAC_W-1:0] D0_FRAC = '0;
`endif

    localparam int unsigned      OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

    cfg_state_e        cfg_st_q;
    logic              cfg_ready_q;
    logic [DIV_W-1:0]  act_int_q;
    logic [FRAC_W-1:0] act_frac_q;
    logic [DIV_W-1:0]  pend_int_q;
    logic [FRAC_W-1:0] pend_frac_q;

    logic [OS_W-1:0]   os_cnt_q;
    logic [OS_W-1:0]   os_cnt_d;
    logic              os_tick_q;
    logic              bit_tick_q;
    logic              baud_q;

    logic              resync_eff;
    logic              period_end;
    logic              bit_end;
    logic              baud_edge;
    logic              apply_now;

    assign resync_eff = enable && resync;
    assign bit_end    = period_end && (os_cnt_q == OS_LAST);
    // Pending divisor goes live on a bit boundary, on resync, or at once while frozen.
    assign apply_now  = (cfg_st_q == CfgPend) && (bit_end || !enable || resync_eff);

    baud_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear      (resync_eff),
        .acc_clear  (apply_now),
        .div_int    (act_int_q),
        .div_frac   (act_frac_q),
        .period_end (period_end)
    );

    // Next oversample index and whether the baud clock flips on this tick.
    always_comb begin
        os_cnt_d  = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
        baud_edge = (os_cnt_d == '0) || (os_cnt_d == OS_HALF);
    end

    // Config slot FSM: accept, hold pending until applied, then reopen one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cfg_st_q    <= CfgIdle;
            cfg_ready_q <= 1'b1;
            act_int_q   <= D0_INT;
            act_frac_q  <= D0_FRAC;
            pend_int_q  <= '0;
            pend_frac_q <= '0;
        end else begin
            unique case (cfg_st_q)
                CfgIdle: begin
                    if (cfg_valid && cfg_ready_q) begin
                        pend_int_q  <= cfg_div_int;
                        pend_frac_q <= cfg_div_frac;
                        cfg_ready_q <= 1'b0;
                        cfg_st_q    <= CfgPend;
                    end
                end
                CfgPend: begin
                    if (apply_now) begin
                        act_int_q  <= pend_int_q;
                        act_frac_q <= pend_frac_q;
                        cfg_st_q   <= CfgDone;
                    end
                end
                CfgDone: begin
                    cfg_ready_q <= 1'b1;
                    cfg_st_q    <= CfgIdle;
                end
                default: begin
                    cfg_ready_q <= 1'b1;
                    cfg_st_q    <= CfgIdle;
                end
            endcase
        end
    end

    // Oversample counter, registered ticks and baud clock; resync overrides a tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            os_cnt_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            baud_q     <= 1'b0;
        end else begin
            os_tick_q  <= period_end;
            bit_tick_q <= bit_end;
            if (resync_eff) begin
                os_cnt_q <= OS_HALF;
                baud_q   <= 1'b1;
            end else if (period_end) begin
                os_cnt_q <= os_cnt_d;
                if (baud_edge) begin
                    baud_q <= ~baud_q;
                end
            end
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign os_tick    = os_tick_q;
    assign bit_tick   = bit_tick_q;
    assign baud_clock = baud_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: expected os_tick times (with bit_tick and
// baud_clock values) are queued when stimulus is set up and compared as ticks appear.
module tb_baud_gen_frac;

    localparam int unsigned FRAC_W = 8;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned OS     = 16;
`ifdef BAUD_GEN_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              resync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              os_tick;
    logic              bit_tick;
    logic              baud_clock;

    typedef struct {
        longint cyc;
        bit     bt;
        bit     bc;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc = 0;
    int     n_tests = 0;
    int     n_fail  = 0;

    baud_gen_frac dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .resync       (resync),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_div_int  (cfg_div_int),
        .cfg_div_frac (cfg_div_frac),
        .os_tick      (os_tick),
        .bit_tick     (bit_tick),
        .baud_clock   (baud_clock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Edges from phase start to the j-th tick: j*int + floor(j*frac / 2^FRAC_W).
    function automatic longint t_of(input longint j, input int unsigned i, input int unsigned f);
        longint ie;
        longint fe;
        ie = (i < 2) ? 2 : longint'(i);
        fe = FRAC_ON ? longint'(f) : 0;
        return j * ie + ((j * fe) >> FRAC_W);
    endfunction

    task automatic push_seg(input longint base, input int unsigned i, input int unsigned f,
                            input int s0, input int j0, input int j1, input longint shift);
        for (int j = j0; j <= j1; j++) begin
            exp_t e;
            int   os;
            os    = (s0 + j) % OS;
            e.cyc = base + t_of(j, i, f) + shift;
            e.bt  = (os == 0);
            e.bc  = (os >= OS / 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input longint n);
        while (cyc < n) @(negedge clk);
    endtask

    // Tick monitor, sampled on the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("os_tick_missing", 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end
        if (os_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("os_tick_unexpected", os_tick, 64'd0);
            end else begin
                check("os_tick_cycle", cyc, exp_q[0].cyc);
                if (exp_q[0].cyc == cyc) begin
                    check("bit_tick", bit_tick, exp_q[0].bt);
                    check("baud_clock", baud_clock, exp_q[0].bc);
                    void'(exp_q.pop_front());
                end
            end
        end else if (bit_tick !== 1'b0) begin
            check("bit_tick_without_os", bit_tick, 64'd0);
        end
    end

    initial begin
        longint e0, b1, b2, h, bend, rz, cend, dapply, dend, e1, g, fend;

        rst          = 1'b0;
        enable       = 1'b1;
        resync       = 1'b0;
        cfg_valid    = 1'b0;
        cfg_div_int  = '0;
        cfg_div_frac = '0;

        wait_cyc(3);
        check("rst_os_tick", os_tick, 64'd0);
        check("rst_bit_tick", bit_tick, 64'd0);
        check("rst_baud_clock", baud_clock, 64'd0);
        check("rst_cfg_ready", cfg_ready, 64'd1);
        e0  = 3;
        rst = 1'b1;

        // Defaults for two bits, then a divisor write mid-bit applied at the next bit.
        push_seg(e0, 39, 16, 0, 1, 32, 0);
        b1 = e0 + t_of(32, 39, 16);
        push_seg(b1, 39, 16, 0, 1, 16, 0);
        b2 = b1 + t_of(16, 39, 16);
        push_seg(b2, 10, 128, 0, 1, 32, 0);
        bend = b2 + t_of(32, 10, 128);
        h    = b1 + t_of(5, 39, 16) + 3;

        wait_cyc(h - 1);
        cfg_valid    = 1'b1;
        cfg_div_int  = 16'd10;
        cfg_div_frac = 8'd128;
        check("cfg_ready_idle", cfg_ready, 64'd1);
        wait_cyc(h);
        cfg_valid    = 1'b0;
        cfg_div_int  = 16'd7;
        cfg_div_frac = 8'd3;
        check("cfg_ready_busy", cfg_ready, 64'd0);
        wait_cyc(b2);
        check("cfg_ready_at_apply", cfg_ready, 64'd0);
        wait_cyc(b2 + 1);
        check("cfg_ready_return", cfg_ready, 64'd1);

        // Resync exactly where the next tick would fall: no tick, bit 8 ticks later.
        rz = bend + t_of(1, 10, 128);
        push_seg(rz, 10, 128, 8, 1, 8, 0);
        cend = rz + t_of(8, 10, 128);
        wait_cyc(rz - 1);
        resync = 1'b1;
        wait_cyc(rz);
        resync = 1'b0;
        check("resync_baud", baud_clock, 64'd1);
        check("resync_no_tick", os_tick, 64'd0);

        // Divisor 0 (clamped to 2) pending, applied at once by a resync.
        dapply = cend + 5;
        push_seg(dapply, 0, 0, 8, 1, 8, 0);
        dend = dapply + t_of(8, 0, 0);
        wait_cyc(cend + 2);
        cfg_valid    = 1'b1;
        cfg_div_int  = 16'd0;
        cfg_div_frac = 8'd0;
        wait_cyc(cend + 3);
        cfg_valid    = 1'b0;
        cfg_div_int  = 16'd500;
        wait_cyc(cend + 4);
        resync = 1'b1;
        wait_cyc(cend + 5);
        resync = 1'b0;
        check("cfg_ready_resync_apply", cfg_ready, 64'd0);
        check("resync2_baud", baud_clock, 64'd1);
        wait_cyc(cend + 6);
        check("cfg_ready_after_resync", cfg_ready, 64'd1);

        // Reset while a divisor is pending, then defaults again with a 100-cycle freeze.
        e1 = dend + 5;
        push_seg(dend, 0, 0, 0, 1, 1, 0);
        push_seg(e1, 39, 16, 0, 1, 24, 0);
        push_seg(e1, 39, 16, 0, 25, 40, 100);
        g    = e1 + t_of(24, 39, 16);
        fend = e1 + t_of(40, 39, 16) + 100;

        wait_cyc(dend);
        cfg_valid    = 1'b1;
        cfg_div_int  = 16'd100;
        cfg_div_frac = 8'd0;
        wait_cyc(dend + 1);
        cfg_valid = 1'b0;
        check("cfg_ready_pending", cfg_ready, 64'd0);
        wait_cyc(dend + 2);
        rst = 1'b0;
        wait_cyc(dend + 3);
        check("midrst_cfg_ready", cfg_ready, 64'd1);
        check("midrst_baud", baud_clock, 64'd0);
        check("midrst_os_tick", os_tick, 64'd0);
        wait_cyc(e1);
        rst = 1'b1;

        wait_cyc(g + 10);
        enable = 1'b0;
        wait_cyc(g + 60);
        check("freeze_baud", baud_clock, 64'd1);
        check("freeze_os_tick", os_tick, 64'd0);
        check("freeze_bit_tick", bit_tick, 64'd0);
        wait_cyc(g + 110);
        enable = 1'b1;

        wait_cyc(fend + 5);
        check("queue_drained", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional baud-rate generator for the UART path: produces an oversampling tick for the receiver, a per-bit tick for the transmitter, and a legacy square-wave `baud_clock`. Divisor is runtime-reprogrammable through a valid/ready handshake and is applied only on bit boundaries. A `resync` input realigns the phase to mid-bit on an RX start edge. Sits between the system clock and the `uart_tx`/`uart_rx` blocks, replacing the fixed integer-only generator.

## Interface
- `CLOCK_FREQ`, 12000000, system clock frequency in Hz
- `BAUD_RATE`, 19200, reset-time baud rate
- `OVERSAMPLE`, 16, os_ticks per bit; even, ≥4
- `DIV_W`, 16, width of integer divisor
- `FRAC_W`, 8, width of fractional divisor
- `clk` in 1 system clock
- `rst` in 1 reset, synchronous, active-low
- `enable` in 1 run when high; freeze when low
- `resync` in 1 one-cycle pulse: restart phase at mid-bit
- `cfg_valid` in 1 new divisor offered
- `cfg_ready` out 1 divisor slot free
- `cfg_div_int` in DIV_W integer clk cycles per os_tick
- `cfg_div_frac` in FRAC_W fractional part, units of 2^-FRAC_W cycle
- `os_tick` out 1 one-cycle pulse per oversample period
- `bit_tick` out 1 one-cycle pulse per bit, coincident with an os_tick
- `baud_clock` out 1 square wave at BAUD_RATE, toggles every OVERSAMPLE/2 os_ticks

## Operation
- Default divisor D0 = CLOCK_FREQ/(BAUD_RATE·OVERSAMPLE) in fixed point: int = floor, frac = round-down of remainder·2^FRAC_W. Defaults: int 39, frac 16.
- Reset (rst=0 at clk edge): os_tick=0, bit_tick=0, baud_clock=0, cfg_ready=1, cycle counter=0, accumulator=0, os_cnt=0, active divisor=D0, pending divisor discarded.
- Period generation: at the start of each os period, {carry, acc} ← acc + div_frac (FRAC_W+1 bits); period length = div_int + carry cycles. div_int < 2 is clamped to 2.
- os_cnt counts os_ticks modulo OVERSAMPLE; bit_tick asserted with the os_tick that wraps os_cnt to 0; baud_clock toggles on os_ticks where os_cnt becomes 0 or OVERSAMPLE/2.
- enable=0: counters, accumulator and baud_clock hold; os_tick/bit_tick forced 0. Resuming continues mid-period, no restart.
- Config handshake: transfer when cfg_valid & cfg_ready; values latched into pending, cfg_ready drops next cycle. Pending applied in the cycle of the next bit_tick (or next cycle if enable=0); cfg_ready returns to 1 the cycle after application. acc cleared on application.
- resync=1: cycle counter and acc cleared, os_cnt ← OVERSAMPLE/2, baud_clock ← 1; next bit_tick exactly OVERSAMPLE/2 os_ticks later. A pending divisor is applied in the same cycle. resync ignored when enable=0.
- Simultaneous resync and os_tick-generating edge: resync wins, no tick emitted.
- Reset mid-operation: full reset state, regardless of pending config or resync.

## Timing
- Outputs registered; no combinational input→output path.
- With enable held high from reset release, first os_tick is high P=div_int(+carry) clock edges after release; defaults: 39 cycles.
- Defaults: 15 periods of 39 + 1 period of 40 → bit_tick every 625 cycles, exactly 12e6/19200.
- cfg_ready low ≥2 cycles per transfer; at most one pending divisor.

## Configuration
- `BAUD_GEN_FRAC_EN` defined: fractional accumulator present as above.
- Undefined: accumulator and carry removed, cfg_div_frac ignored, D0 frac forced 0; period = div_int always (defaults: bit_tick every 624 cycles).

## Structure
- Package `baud_pkg`: DIV_W/FRAC_W defaults, D0 computation function, minimum-divisor constant.
- Sub-module `baud_frac_div`: cycle counter + accumulator producing os_tick from active divisor, with clear and enable inputs. Top handles os_cnt, bit_tick, baud_clock, config handshake, resync.

## Test plan
- Reset release, enable=1, defaults → os_tick at cycle 39, 16th period 40 cycles, bit_tick period 625, baud_clock period 625 with 50/50 split ±1 os period.
- cfg write int=10 frac=128 mid-bit → cfg_ready low, old divisor until next bit_tick, then os periods alternate 10/11, bit_tick period 168.
- resync pulse at arbitrary point → baud_clock=1 next cycle, bit_tick exactly 8 os_ticks later, no tick in resync cycle.
- enable low for 100 cycles mid-period → no ticks, outputs frozen; resume finishes remaining period count.
- cfg int=0 → clamped to 2, os_tick every 2 cycles; rst=0 mid-pending → cfg_ready=1, divisor back to 39/16.
- Build without `BAUD_GEN_FRAC_EN` → os_tick every 39 cycles, bit_tick every 624, cfg_div_frac has no effect.
